// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the instruction sequencer.
//   - opcode values, FSM state encoding, write-back source codes
//   - instruction field bit positions
//   - ctl_t: per-instruction action flags produced by instr_decode
package seq_pkg;

   localparam logic [3:0] OP_OUT0 = 4'h0;
   localparam logic [3:0] OP_LOAD = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_SUBI = 4'hB;
   localparam logic [3:0] OP_BR   = 4'hC;
   localparam logic [3:0] OP_MOV  = 4'hE;
   localparam logic [3:0] OP_OUT1 = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC
   } state_t;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_IMM = 2'd1;
   localparam logic [1:0] WB_RB  = 2'd2;

   localparam int unsigned OP_MSB  = 15;
   localparam int unsigned OP_LSB  = 12;
   localparam int unsigned RD_MSB  = 11;
   localparam int unsigned RD_LSB  = 9;
   localparam int unsigned RS_MSB  = 8;
   localparam int unsigned RS_LSB  = 6;
   localparam int unsigned IMM_MSB = 7;
   localparam int unsigned IMM_LSB = 0;
   localparam int unsigned TGT_MSB = 11;
   localparam int unsigned TGT_LSB = 8;

   typedef struct packed {
      logic wr;     // register-file write in EXEC
      logic out;    // output-register load in EXEC
      logic upd_z;  // capture alu_zero into flag_z
      logic jmp;    // unconditional pc load
      logic br;     // pc load when flag_z is set
   } ctl_t;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational decode of the instruction register.
// Ports:
//   ir        in   instruction register
//   rf_ra     out  read port A address (rd)
//   rf_rb     out  read port B address (rs)
//   rf_wa     out  write address (rd)
//   imm       out  ir[7:0]
//   wb_sel    out  write-back source (WB_ALU / WB_IMM / WB_RB)
//   alu_op    out  0 add, 1 subtract
//   alu_b_imm out  ALU operand B is imm
//   target    out  jump / branch target ir[11:8]
//   ctl       out  action flags, qualified by the FSM
module instr_decode
   import seq_pkg::*;
#(
   parameter int PC_W = 4,
   parameter int IW   = 16,
   parameter int RA_W = 3
) (
   input  logic [IW-1:0]   ir,
   output logic [RA_W-1:0] rf_ra,
   output logic [RA_W-1:0] rf_rb,
   output logic [RA_W-1:0] rf_wa,
   output logic [7:0]      imm,
   output logic [1:0]      wb_sel,
   output logic            alu_op,
   output logic            alu_b_imm,
   output logic [PC_W-1:0] target,
   output ctl_t            ctl
);

   logic [3:0] op;

   assign op     = ir[OP_MSB:OP_LSB];
   assign rf_ra  = ir[RD_MSB:RD_LSB];
   assign rf_rb  = ir[RS_MSB:RS_LSB];
   assign rf_wa  = ir[RD_MSB:RD_LSB];
   assign imm    = ir[IMM_MSB:IMM_LSB];
   assign target = ir[TGT_MSB:TGT_LSB];

   always_comb begin
      wb_sel    = WB_ALU;
      alu_op    = 1'b0;
      alu_b_imm = 1'b0;
      ctl       = '0;
      case (op)
         OP_OUT0, OP_OUT1: ctl.out = 1'b1;
         OP_LOAD: begin
            ctl.wr = 1'b1;
            wb_sel = WB_IMM;
         end
         OP_ADD: begin
            ctl.wr    = 1'b1;
            ctl.upd_z = 1'b1;
         end
         OP_SUB: begin
            ctl.wr    = 1'b1;
            ctl.upd_z = 1'b1;
            alu_op    = 1'b1;
         end
         OP_SUBI: begin
            ctl.wr    = 1'b1;
            ctl.upd_z = 1'b1;
            alu_op    = 1'b1;
            alu_b_imm = 1'b1;
         end
         OP_MOV: begin
            ctl.wr = 1'b1;
            wb_sel = WB_RB;
         end
         OP_JMP:  ctl.jmp = 1'b1;
         OP_BR:   ctl.br  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: 3-cycle-per-instruction control unit (IDLE/FETCH/DECODE/EXEC).
// Owns pc, ir and the zero flag; drives ROM address and datapath strobes.
// Optional macro SEQ_STEP_EN adds a 'step' input for single-instruction execution.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   run                 1 = execute continuously, 0 = halt at instruction boundary
//   step                (SEQ_STEP_EN only) rising edge in IDLE runs one instruction
//   rom_addr / rom_data ROM address (= pc) and combinational read data
//   alu_zero            ALU result is zero
//   rf_ra/rf_rb/rf_wa   register-file addresses
//   rf_we, out_we       one-cycle strobes in EXEC
//   wb_sel, alu_op, alu_b_imm, imm   datapath controls decoded from ir
//   flag_z              registered zero flag
//   busy                FSM not in IDLE
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int PC_W = 4,
   parameter int IW   = 16,
   parameter int RA_W = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
`ifdef SEQ_STEP_EN
   input  logic            step,
`endif
   output logic [PC_W-1:0] rom_addr,
   input  logic [IW-1:0]   rom_data,
   input  logic            alu_zero,
   output logic [RA_W-1:0] rf_ra,
   output logic [RA_W-1:0] rf_rb,
   output logic [RA_W-1:0] rf_wa,
   output logic            rf_we,
   output logic [1:0]      wb_sel,
   output logic            alu_op,
   output logic            alu_b_imm,
   output logic [7:0]      imm,
   output logic            out_we,
   output logic            flag_z,
   output logic            busy
);

   state_t          state_q;
   state_t          state_d;
   logic [PC_W-1:0] pc;
   logic [IW-1:0]   ir;
   logic [PC_W-1:0] target;
   ctl_t            ctl;
   logic            start;

`ifdef SEQ_STEP_EN
   logic step_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) step_q <= 1'b0;
      else        step_q <= step;
   end

   // The edge is only consumed from IDLE, so pulses elsewhere have no effect.
   assign start = run | (step & ~step_q);
`else
   assign start = run;
`endif

   instr_decode #(
      .PC_W (PC_W),
      .IW   (IW),
      .RA_W (RA_W)
   ) u_decode (
      .ir        (ir),
      .rf_ra     (rf_ra),
      .rf_rb     (rf_rb),
      .rf_wa     (rf_wa),
      .imm       (imm),
      .wb_sel    (wb_sel),
      .alu_op    (alu_op),
      .alu_b_imm (alu_b_imm),
      .target    (target),
      .ctl       (ctl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      rf_we   = 1'b0;
      out_we  = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   state_d = DECODE;
         DECODE:  state_d = EXEC;
         EXEC: begin
            rf_we   = ctl.wr;
            out_we  = ctl.out;
            state_d = run ? FETCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= '0;
         ir     <= '0;
         flag_z <= 1'b0;
      end else begin
         if (state_q == FETCH) begin
            ir <= rom_data;
            pc <= pc + PC_W'(1);
         end
         if (state_q == EXEC) begin
            if (ctl.upd_z) flag_z <= alu_zero;
            // BR sees the flag from before this EXEC since flag_z is registered.
            if (ctl.jmp || (ctl.br && flag_z)) pc <= target;
         end
      end
   end

   assign rom_addr = pc;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [3:0]  rom_addr;
   logic [15:0] rom_data;
   logic        alu_zero;
   logic [2:0]  rf_ra;
   logic [2:0]  rf_rb;
   logic [2:0]  rf_wa;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic        alu_op;
   logic        alu_b_imm;
   logic [7:0]  imm;
   logic        out_we;
   logic        flag_z;
   logic        busy;
`ifdef SEQ_STEP_EN
   logic        step;
   initial step = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] rom [16];
   logic [7:0]  rf_m [8] = '{default: 8'h00};
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [7:0]  alu_y;
   logic [7:0]  exp_q [$];

   instr_sequencer #(
      .PC_W (4),
      .IW   (16),
      .RA_W (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
`ifdef SEQ_STEP_EN
      .step      (step),
`endif
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .alu_zero  (alu_zero),
      .rf_ra     (rf_ra),
      .rf_rb     (rf_rb),
      .rf_wa     (rf_wa),
      .rf_we     (rf_we),
      .wb_sel    (wb_sel),
      .alu_op    (alu_op),
      .alu_b_imm (alu_b_imm),
      .imm       (imm),
      .out_we    (out_we),
      .flag_z    (flag_z),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath model: ROM, 8-bit register file and ALU.
   assign rom_data = rom[rom_addr];

   always_comb begin
      alu_a    = rf_m[rf_ra];
      alu_b    = alu_b_imm ? imm : rf_m[rf_rb];
      alu_y    = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);
      alu_zero = (alu_y == 8'h00);
   end

   always @(posedge clk) begin
      if (rf_we) begin
         case (wb_sel)
            2'd0:    rf_m[rf_wa] <= alu_y;
            2'd1:    rf_m[rf_wa] <= imm;
            2'd2:    rf_m[rf_wa] <= rf_m[rf_rb];
            default: ;
         endcase
      end
   end

   task automatic fill_rom(input logic [15:0] w);
      for (int i = 0; i < 16; i++) rom[i] = w;
   endtask

   task automatic do_reset();
      run   = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      fill_rom(16'h4000);
      do_reset();
      for (int c = 0; c < 10; c++) begin
         n_cmp++;
         if (rom_addr !== 4'd0 || busy !== 1'b0 || rf_we !== 1'b0 || out_we !== 1'b0 || flag_z !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle c=%0d: got pc=%0h busy=%b rf_we=%b out_we=%b z=%b, need 0/0/0/0/0",
                     c, rom_addr, busy, rf_we, out_we, flag_z);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_load();
      fill_rom(16'h4000);
      rom[0] = 16'h120A;
      do_reset();
      run = 1'b1;
      @(negedge clk);  // FETCH
      n_cmp++;
      if (busy !== 1'b1 || rom_addr !== 4'd0 || rf_we !== 1'b0) begin
         n_bad++;
         $display("FAIL load_fetch: got busy=%b pc=%0h rf_we=%b, need 1/0/0", busy, rom_addr, rf_we);
      end
      @(negedge clk);  // DECODE
      run = 1'b0;
      n_cmp++;
      if (rom_addr !== 4'd1 || rf_ra !== 3'd1 || imm !== 8'h0A || rf_we !== 1'b0 || out_we !== 1'b0) begin
         n_bad++;
         $display("FAIL load_decode: got pc=%0h ra=%0d imm=%0h we=%b ow=%b, need 1/1/0a/0/0",
                  rom_addr, rf_ra, imm, rf_we, out_we);
      end
      @(negedge clk);  // EXEC
      n_cmp++;
      if (rf_we !== 1'b1 || rf_wa !== 3'd1 || wb_sel !== 2'd1 || imm !== 8'h0A || out_we !== 1'b0) begin
         n_bad++;
         $display("FAIL load_exec: got we=%b wa=%0d wb=%0d imm=%0h ow=%b, need 1/1/1/0a/0",
                  rf_we, rf_wa, wb_sel, imm, out_we);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || rom_addr !== 4'd1 || rf_m[1] !== 8'h0A) begin
         n_bad++;
         $display("FAIL load_after: got busy=%b pc=%0h r1=%0h, need 0/1/0a", busy, rom_addr, rf_m[1]);
      end
   endtask

   task automatic test_countdown();
      logic [7:0] e;
      int         cyc;
      fill_rom(16'h4000);
      rom[0]  = 16'h1E0F;  // load r7,15
      rom[1]  = 16'h1255;  // load r1,0x55
      rom[2]  = 16'h0E00;  // out r7
      rom[3]  = 16'hBE01;  // subi r7,1
      rom[4]  = 16'hCA00;  // br 10
      rom[5]  = 16'h8200;  // jmp 2
      rom[10] = 16'h0200;  // out r1
      rom[11] = 16'h8A00;  // jmp 10
      exp_q.delete();
      for (int v = 15; v >= 1; v--) exp_q.push_back(8'(v));
      repeat (3) exp_q.push_back(8'h55);
      do_reset();
      run = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 600) begin
         @(negedge clk);
         cyc++;
         if (out_we) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rf_m[rf_ra] !== e) begin
               n_bad++;
               $display("FAIL countdown_out: got %0h need %0h", rf_m[rf_ra], e);
            end
            if (e == 8'h55) begin
               n_cmp++;
               if (rom_addr !== 4'd11 || rf_ra !== 3'd1) begin
                  n_bad++;
                  $display("FAIL countdown_br_target: got pc=%0h ra=%0d need b/1", rom_addr, rf_ra);
               end
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL countdown_timeout: got %0d outputs left, need 0", exp_q.size());
      end
      n_cmp++;
      if (flag_z !== 1'b1) begin
         n_bad++;
         $display("FAIL countdown_flag: got %b need 1", flag_z);
      end
      run = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_alu_ops();
      logic [7:0] e;
      int         cyc;
      int         extra;
      fill_rom(16'h4000);
      rom[0]  = 16'h1205;  // load r1,5
      rom[1]  = 16'h1405;  // load r2,5
      rom[2]  = 16'h3280;  // sub r1,r2 -> 0
      rom[3]  = 16'h0200;  // out r1
      rom[4]  = 16'h2480;  // add r2,r2 -> 10
      rom[5]  = 16'h0400;  // out r2
      rom[6]  = 16'hE880;  // mov r4,r2
      rom[7]  = 16'hF800;  // out r4 (opcode 1111)
      rom[8]  = 16'hCC00;  // br 12, not taken
      rom[9]  = 16'h0200;  // out r1
      rom[10] = 16'h8A00;  // jmp 10 (self-loop)
      rom[12] = 16'h0400;  // out r2, only reached on a wrong branch
      exp_q.delete();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h00);
      do_reset();
      run = 1'b1;
      cyc = 0;
      extra = 0;
      while (cyc < 90) begin
         @(negedge clk);
         cyc++;
         if (out_we) begin
            if (exp_q.size() == 0) extra++;
            else begin
               e = exp_q.pop_front();
               n_cmp++;
               if (rf_m[rf_ra] !== e) begin
                  n_bad++;
                  $display("FAIL alu_out: got %0h need %0h", rf_m[rf_ra], e);
               end
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0 || extra != 0) begin
         n_bad++;
         $display("FAIL alu_out_count: got left=%0d extra=%0d need 0/0", exp_q.size(), extra);
      end
      n_cmp++;
      if (flag_z !== 1'b0 || (rom_addr !== 4'd10 && rom_addr !== 4'd11)) begin
         n_bad++;
         $display("FAIL alu_selfloop: got z=%b pc=%0h need 0 and pc a/b", flag_z, rom_addr);
      end
      run = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_wrap();
      logic [7:0] e;
      int         cyc;
      int         last;
      fill_rom(16'h0000);
      exp_q.delete();
      for (int i = 0; i < 18; i++) exp_q.push_back(8'((i + 1) % 16));
      do_reset();
      run = 1'b1;
      cyc = 0;
      last = -1;
      while (exp_q.size() != 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (out_we) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({4'h0, rom_addr} !== e || rf_ra !== 3'd0) begin
               n_bad++;
               $display("FAIL wrap_pc: got pc=%0h ra=%0d need %0h/0", rom_addr, rf_ra, e);
            end
            if (last >= 0) begin
               n_cmp++;
               if (cyc - last != 3) begin
                  n_bad++;
                  $display("FAIL wrap_spacing: got %0d clk need 3", cyc - last);
               end
            end
            last = cyc;
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL wrap_timeout: got %0d left need 0", exp_q.size());
      end
      run = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_halt_resume();
      fill_rom(16'h4000);
      rom[4] = 16'h0E00;  // out r7
      do_reset();
      run = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);  // DECODE of addr 3
      n_cmp++;
      if (rom_addr !== 4'd4 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL halt_decode: got pc=%0h busy=%b need 4/1", rom_addr, busy);
      end
      run = 1'b0;
      @(negedge clk);  // EXEC of addr 3 still runs
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL halt_exec: got busy=%b need 1", busy);
      end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || rom_addr !== 4'd4 || out_we !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_idle: got busy=%b pc=%0h ow=%b need 0/4/0", busy, rom_addr, out_we);
      end
      run = 1'b1;
      @(negedge clk);  // FETCH addr 4
      n_cmp++;
      if (busy !== 1'b1 || rom_addr !== 4'd4) begin
         n_bad++;
         $display("FAIL resume_fetch: got busy=%b pc=%0h need 1/4", busy, rom_addr);
      end
      @(negedge clk);
      @(negedge clk);  // EXEC of out r7
      n_cmp++;
      if (out_we !== 1'b1 || rf_ra !== 3'd7 || rom_addr !== 4'd5) begin
         n_bad++;
         $display("FAIL resume_exec: got ow=%b ra=%0d pc=%0h need 1/7/5", out_we, rf_ra, rom_addr);
      end
      run = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_async_reset();
      fill_rom(16'h4000);
      rom[0] = 16'h1401;  // load r2,1
      rom[1] = 16'hB401;  // subi r2,1 -> flag_z = 1
      rom[2] = 16'h1605;  // load r3,5
      do_reset();
      run = 1'b1;
      repeat (9) @(posedge clk);
      @(negedge clk);  // EXEC of addr 2
      n_cmp++;
      if (rf_we !== 1'b1 || flag_z !== 1'b1 || rom_addr !== 4'd3) begin
         n_bad++;
         $display("FAIL areset_pre: got we=%b z=%b pc=%0h need 1/1/3", rf_we, flag_z, rom_addr);
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rf_we !== 1'b0 || rom_addr !== 4'd0 || flag_z !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL areset_now: got we=%b pc=%0h z=%b busy=%b need 0/0/0/0",
                  rf_we, rom_addr, flag_z, busy);
      end
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      run   = 1'b0;
      fill_rom(16'h4000);
      test_reset();
      test_load();
      test_countdown();
      test_alu_ops();
      test_wrap();
      test_halt_resume();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control unit that sequences the 16-entry x 16-bit program ROM through the datapath (register file, ALU, output register).
- Owns the program counter, instruction register and zero flag.
- Drives the ROM address and decodes each fetched word into register-file, ALU and output strobes.
- Fixed 3-cycle-per-instruction FSM, with run/halt control from the top level.

Parameters:
- PC_W, 4, program counter / ROM address width (16 words)
- IW, 16, instruction width
- RA_W, 3, register address width (r0-r7)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = execute continuously, 0 = halt at next instruction boundary
- rom_addr  out  PC_W  ROM address, equal to pc
- rom_data  in  IW  instruction from ROM (combinational read)
- alu_zero  in  1  ALU result == 0
- rf_ra  out  RA_W  read port A address (rd field)
- rf_rb  out  RA_W  read port B address (rs field)
- rf_wa  out  RA_W  write address (rd field)
- rf_we  out  1  register write strobe, one cycle
- wb_sel  out  2  write-back source: 0 ALU, 1 immediate, 2 port B
- alu_op  out  1  0 add, 1 subtract
- alu_b_imm  out  1  ALU operand B: 1 = imm, 0 = port B
- imm  out  8  ir[7:0]
- out_we  out  1  output-register load strobe (value = port A)
- flag_z  out  1  registered zero flag
- busy  out  1  FSM not in IDLE

Behaviour:
- Encoding: op = ir[15:12], rd = ir[11:9], rs = ir[8:6], imm = ir[7:0], target = ir[11:8].
- Opcodes:
  - 0000 / 1111 OUT rd
  - 0001 LOAD rd, imm
  - 0010 ADD rd, rs
  - 0011 SUB rd, rs
  - 1011 SUBI rd, imm
  - 1110 MOV rd, rs
  - 1000 JMP target
  - 1100 BR target (taken if flag_z = 1)
  - All other opcodes are NOP.
- Reset (async):
  - pc = 0, ir = 0, flag_z = 0, state = IDLE.
  - rf_we = out_we = 0; busy = 0.
- States:
  - IDLE: stays until run = 1, then goes to FETCH.
  - FETCH: ir <= rom_data; pc <= pc+1 (wraps 15 -> 0); next state DECODE.
  - DECODE: rf_ra/rf_rb/imm are valid from ir; no strobes; next state EXEC.
  - EXEC: asserts the strobes for the op; next state is FETCH if run = 1, else IDLE.
- rf_ra, rf_rb, rf_wa, imm, wb_sel, alu_op and alu_b_imm are combinational decodes of ir. They are stable through DECODE and EXEC.
- rf_we and out_we are asserted only in EXEC:
  - LOAD: rf_we, wb_sel = 1.
  - ADD: rf_we, wb_sel = 0, alu_op = 0, alu_b_imm = 0.
  - SUB: same as ADD with alu_op = 1.
  - SUBI: rf_we, wb_sel = 0, alu_op = 1, alu_b_imm = 1.
  - MOV: rf_we, wb_sel = 2.
  - OUT: out_we.
- Zero flag: flag_z <= alu_zero at the end of EXEC for ADD, SUB and SUBI only. All other ops hold it.
- JMP: pc <= target at the end of EXEC.
- BR: pc <= target if flag_z = 1; otherwise pc keeps its incremented value. The flag value used is the one before this EXEC.
- Self-jump (target == fetch address) is legal and loops indefinitely.
- run falling in FETCH or DECODE: the current instruction completes, then the FSM goes to IDLE. pc points at the next instruction, so a later run = 1 resumes there.
- rst_n asserted mid-instruction: immediate abort. No partial strobe survives; state returns to reset values.
- Throughput: 1 instruction per 3 clk; rom_addr changes only on FETCH/EXEC edges.

Optional Feature:
- Macro: SEQ_STEP_EN.
- Defined:
  - Adds port step (in, 1). A step rising edge seen in IDLE while run = 0 executes exactly one instruction (FETCH, DECODE, EXEC), then returns to IDLE.
  - The edge detector is internal and reset to 0.
  - step pulses outside IDLE are ignored.
- Undefined: no step port; IDLE exits only on run.

Decomposition:
- Package seq_pkg holds:
  - opcode localparams (OP_OUT0, OP_LOAD, OP_ADD, OP_SUB, OP_JMP, OP_SUBI, OP_BR, OP_MOV, OP_OUT1);
  - state encoding (IDLE, FETCH, DECODE, EXEC);
  - WB_ALU/WB_IMM/WB_RB codes;
  - field bit positions.
- One natural sub-module, instr_decode: purely combinational ir -> control fields. The FSM, pc, ir and flag stay in instr_sequencer.

Test Plan:
- Reset and idle:
  - Hold rst_n = 0, then release with run = 0 for 10 clk.
  - Expect pc = 0, busy = 0, and no rf_we/out_we.
- LOAD:
  - run = 1, ROM[0] = 0x120A (load r1,10).
  - In EXEC cycle 3, expect rf_we = 1, rf_wa = 1, wb_sel = 1, imm = 0x0A. pc = 1 after FETCH.
- Countdown loop with modelled ALU:
  - Program: load r7,15; out r7; subi r7,1; br 10; jmp 2.
  - Expect out_we 15 times with r7 = 15..1.
  - BR is taken once flag_z = 1; pc reaches 10 and OUT r1 then repeats via jmp 10.
- Wrap-around: ROM all zero. Expect pc to go 15 -> 0, with out_we every 3 clk and rf_ra = 0.
- Halt and resume: drop run during DECODE of addr 3. Expect EXEC to complete, then IDLE with pc = 4. Raising run fetches addr 4.
- Async reset mid-EXEC: assert rst_n low between edges. Expect rf_we to drop immediately, and pc = 0, flag_z = 0 with no clock edge.
